// File: rtl/gp_rect_engine_if.sv
// Bus bundle for gp_rect_engine: CPU register strobes, the finish flag and the VRAM write port.
// master = CPU/bus-decoder/VRAM side, slave = drawing engine.
interface gp_rect_engine_if #(
  parameter int unsigned AW = 17,
  parameter int unsigned CW = 12
);
  logic          ctrl_we;
  logic [31:0]   ctrl_in;
  logic          tl_we;
  logic [31:0]   tl_in;
  logic          br_we;
  logic [31:0]   br_in;
  logic          arg_we;
  logic [31:0]   arg_in;
  logic          finish;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [CW-1:0] vram_data;
  logic          vram_stall;

  modport master (
    output ctrl_we, ctrl_in, tl_we, tl_in, br_we, br_in, arg_we, arg_in, vram_stall,
    input  finish, vram_we, vram_addr, vram_data
  );

  modport slave (
    input  ctrl_we, ctrl_in, tl_we, tl_in, br_we, br_in, arg_we, arg_in, vram_stall,
    output finish, vram_we, vram_addr, vram_data
  );
endinterface

// File: rtl/gp_rect_engine.sv
// gp_rect_engine: memory-mapped rectangle fill / clear / frame engine streaming pixel writes
// into VRAM. Optional outline drawing (op 2) is enabled by defining GP_FRAME_EN; without it
// op 2 behaves as an empty op.
module gp_rect_engine #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 240,
  parameter int unsigned AW    = 17,
  parameter int unsigned CW    = 12
) (
  input  logic            clk,
  input  logic            rst,
  gp_rect_engine_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StDraw, StDone} state_e;

  localparam logic [1:0]    OpFill  = 2'd0;
  localparam logic [1:0]    OpClear = 2'd1;
`ifdef GP_FRAME_EN
  localparam logic [1:0]    OpFrame = 2'd2;
`endif
  localparam logic [9:0]    XMax    = 10'(H_RES - 1);
  localparam logic [9:0]    YMax    = 10'(V_RES - 1);
  localparam logic [AW-1:0] HStep   = AW'(H_RES);

  state_e        state_q, state_d;
  logic [9:0]    tl_x_q, tl_x_d, tl_y_q, tl_y_d, br_x_q, br_x_d, br_y_q, br_y_d;
  logic [CW-1:0] color_q, color_d, dcol_q, dcol_d;
  logic [1:0]    op_q, op_d;
  logic [9:0]    x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d, x_q, x_d, y_q, y_d;
  logic [AW-1:0] row_q, row_d, addr_q, addr_d;
  logic [CW-1:0] data_q, data_d;
  logic          we_q, we_d;

  logic [9:0]    cx0, cx1, cy0, cy1;
  logic          empty_op, last_px;

  // Bits of the bus words that carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{bus.ctrl_in[31:3], bus.tl_in[31:26], bus.tl_in[15:10],
                         bus.br_in[31:26], bus.br_in[15:10], bus.arg_in[31:CW]};

  // Snapshot corners clipped to the screen; only meaningful in SETUP.
  assign cx0 = (x0_q > XMax) ? XMax : x0_q;
  assign cx1 = (x1_q > XMax) ? XMax : x1_q;
  assign cy0 = (y0_q > YMax) ? YMax : y0_q;
  assign cy1 = (y1_q > YMax) ? YMax : y1_q;
  assign last_px = (x_q == x1_q) && (y_q == y1_q);

  assign bus.finish    = (state_q == StIdle);
  assign bus.vram_we   = we_q;
  assign bus.vram_addr = addr_q;
  assign bus.vram_data = data_q;

  // Decide whether the latched op produces no pixels at all.
  always_comb begin
    empty_op = (cx0 > cx1) || (cy0 > cy1);
    case (op_q)
      OpFill, OpClear: empty_op = empty_op;
`ifdef GP_FRAME_EN
      OpFrame:         empty_op = empty_op;
`endif
      default:         empty_op = 1'b1;
    endcase
  end

  // Next-state, register loads and the pixel walker.
  always_comb begin
    state_d = state_q;
    tl_x_d  = tl_x_q;
    tl_y_d  = tl_y_q;
    br_x_d  = br_x_q;
    br_y_d  = br_y_q;
    color_d = color_q;
    dcol_d  = dcol_q;
    op_d    = op_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.tl_we) begin
          tl_x_d = bus.tl_in[25:16];
          tl_y_d = bus.tl_in[9:0];
        end
        if (bus.br_we) begin
          br_x_d = bus.br_in[25:16];
          br_y_d = bus.br_in[9:0];
        end
        if (bus.arg_we) color_d = bus.arg_in[CW-1:0];
        // The op works on a snapshot of the registers as they were before this cycle.
        if (bus.ctrl_we && bus.ctrl_in[0]) begin
          state_d = StSetup;
          op_d    = bus.ctrl_in[2:1];
          dcol_d  = color_q;
          if (bus.ctrl_in[2:1] == OpClear) begin
            x0_d = '0;
            y0_d = '0;
            x1_d = XMax;
            y1_d = YMax;
          end else begin
            x0_d = tl_x_q;
            y0_d = tl_y_q;
            x1_d = br_x_q;
            y1_d = br_y_q;
          end
        end
      end
      StSetup: begin
        x0_d  = cx0;
        x1_d  = cx1;
        y0_d  = cy0;
        y1_d  = cy1;
        x_d   = cx0;
        y_d   = cy0;
        row_d = AW'(cy0) * HStep;
        if (empty_op) begin
          state_d = StDone;
        end else begin
          state_d = StDraw;
          we_d    = 1'b1;
          addr_d  = row_d + AW'(cx0);
          data_d  = dcol_q;
        end
      end
      StDraw: begin
        if (!bus.vram_stall) begin
          if (last_px) begin
            we_d    = 1'b0;
            state_d = StDone;
          end else begin
            if (x_q == x1_q) begin
              x_d   = x0_q;
              y_d   = y_q + 10'd1;
              row_d = row_q + HStep;
`ifdef GP_FRAME_EN
            end else if (op_q == OpFrame && x_q == x0_q && y_q != y0_q && y_q != y1_q) begin
              // Interior outline row: skip straight to the right edge.
              x_d = x1_q;
`endif
            end else begin
              x_d = x_q + 10'd1;
            end
            addr_d = row_d + AW'(x_d);
          end
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tl_x_q  <= '0;
      tl_y_q  <= '0;
      br_x_q  <= '0;
      br_y_q  <= '0;
      color_q <= '0;
      dcol_q  <= '0;
      op_q    <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tl_x_q  <= tl_x_d;
      tl_y_q  <= tl_y_d;
      br_x_q  <= br_x_d;
      br_y_q  <= br_y_d;
      color_q <= color_d;
      dcol_q  <= dcol_d;
      op_q    <= op_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_gp_rect_engine.sv
// Self-checking bench for gp_rect_engine: directed steps plus randomized rectangles checked
// against a pixel-list reference model built from the drawing rules.
module tb_gp_rect_engine;
  localparam int H_RES = 320;
  localparam int V_RES = 240;
  localparam int AW    = 17;
  localparam int CW    = 12;
`ifdef GP_FRAME_EN
  localparam bit FRAME_EN = 1'b1;
`else
  localparam bit FRAME_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gp_rect_engine_if #(.AW(AW), .CW(CW)) bus ();

  gp_rect_engine #(.H_RES(H_RES), .V_RES(V_RES), .AW(AW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: registers as the CPU believes they are.
  logic [31:0] m_tl, m_br, m_col;
  int          exp_q[$];
  logic [31:0] exp_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected raster-order address list for an op on the model registers.
  function automatic void build_exp(input logic [1:0] op);
    int x0, x1, y0, y1;
    exp_q.delete();
    exp_col = {20'd0, m_col[CW-1:0]};
    x0 = int'(m_tl[25:16]);
    y0 = int'(m_tl[9:0]);
    x1 = int'(m_br[25:16]);
    y1 = int'(m_br[9:0]);
    if (x0 > H_RES - 1) x0 = H_RES - 1;
    if (x1 > H_RES - 1) x1 = H_RES - 1;
    if (y0 > V_RES - 1) y0 = V_RES - 1;
    if (y1 > V_RES - 1) y1 = V_RES - 1;
    if (op == 2'd1) begin
      x0 = 0; y0 = 0; x1 = H_RES - 1; y1 = V_RES - 1;
    end
    if (op == 2'd3 || (op == 2'd2 && !FRAME_EN)) return;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        if (op != 2'd2 || x == x0 || x == x1 || y == y0 || y == y1)
          exp_q.push_back(y * H_RES + x);
  endfunction

  // Entered and left at posedge+1.
  task automatic wr(input int which, input logic [31:0] v);
    case (which)
      0: begin bus.tl_we = 1'b1; bus.tl_in = v; m_tl = v; end
      1: begin bus.br_we = 1'b1; bus.br_in = v; m_br = v; end
      default: begin bus.arg_we = 1'b1; bus.arg_in = v; m_col = v; end
    endcase
    @(posedge clk); #1;
    bus.tl_we = 1'b0; bus.br_we = 1'b0; bus.arg_we = 1'b0;
  endtask

  function automatic logic [31:0] xy(input int x, input int y);
    logic [9:0] xx, yy;
    xx = 10'(x);
    yy = 10'(y);
    return {$urandom_range(0, 63) , xx, 6'($urandom_range(0, 63)), yy} ;
  endfunction

  // Start an op and follow it to completion, checking every write and the finish latency.
  task automatic do_op(input string tag, input logic [1:0] op, input int stall_pct,
                       input int stall_at, input bit tl_with_start, input logic [31:0] tl_new,
                       input bit busy_tl);
    int acc, stl, dstl, c;
    bit st;
    build_exp(op);
    bus.ctrl_we = 1'b1;
    bus.ctrl_in = {29'($urandom), op, 1'b1};
    if (tl_with_start) begin bus.tl_we = 1'b1; bus.tl_in = tl_new; end
    @(posedge clk); #1;
    bus.ctrl_we = 1'b0;
    bus.tl_we   = 1'b0;
    if (tl_with_start) m_tl = tl_new;
    acc = 0; stl = 0; dstl = 0; c = 1;
    check({tag, " busy"}, {31'd0, bus.finish}, 32'd0);
    while (!bus.finish && c < 4000) begin
      st = (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) ||
           (acc == stall_at && dstl < 2);
      bus.vram_stall = st;
      if (busy_tl && c == 2) begin bus.tl_we = 1'b1; bus.tl_in = $urandom; end
      else bus.tl_we = 1'b0;
      if (bus.vram_we) begin
        if (acc < exp_q.size()) begin
          check({tag, " addr"}, 32'(bus.vram_addr), 32'(exp_q[acc]));
          check({tag, " data"}, 32'(bus.vram_data), exp_col);
        end else begin
          check({tag, " extra write"}, 32'(acc + 1), 32'(exp_q.size()));
        end
        if (st) begin
          stl++;
          if (acc == stall_at) dstl++;
        end else begin
          acc++;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    bus.vram_stall = 1'b0;
    bus.tl_we      = 1'b0;
    check({tag, " finish"}, {31'd0, bus.finish}, 32'd1);
    check({tag, " count"}, 32'(acc), 32'(exp_q.size()));
    check({tag, " latency"}, 32'(c), 32'(exp_q.size() + stl + 3));
    check({tag, " we idle"}, {31'd0, bus.vram_we}, 32'd0);
  endtask

  initial begin
    bus.ctrl_we = 1'b0; bus.ctrl_in = '0; bus.tl_we = 1'b0; bus.tl_in = '0;
    bus.br_we = 1'b0; bus.br_in = '0; bus.arg_we = 1'b0; bus.arg_in = '0;
    bus.vram_stall = 1'b0;
    m_tl = '0; m_br = '0; m_col = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset finish", {31'd0, bus.finish}, 32'd1);
    check("reset we", {31'd0, bus.vram_we}, 32'd0);
    check("reset addr", 32'(bus.vram_addr), 32'd0);
    check("reset data", 32'(bus.vram_data), 32'd0);
    @(posedge clk); #1;
    check("idle we", {31'd0, bus.vram_we}, 32'd0);

    // Basic 3x2 fill.
    wr(0, xy(2, 1)); wr(1, xy(4, 2)); wr(2, 32'hABCD_1F00);
    do_op("fill3x2", 2'd0, 0, -1, 1'b0, '0, 1'b0);
    // Clipping at the bottom-right corner.
    wr(0, xy(318, 238)); wr(1, xy(500, 300));
    do_op("clip", 2'd0, 0, -1, 1'b0, '0, 1'b0);
    // Inverted rectangle and reserved op.
    wr(0, xy(5, 5)); wr(1, xy(3, 5));
    do_op("inverted", 2'd0, 0, -1, 1'b0, '0, 1'b0);
    wr(1, xy(7, 6));
    do_op("op3", 2'd3, 0, -1, 1'b0, '0, 1'b0);
    // 3x1 fill with a two-cycle stall on the second pixel.
    wr(0, xy(0, 0)); wr(1, xy(2, 0)); wr(2, 32'h0000_0123);
    do_op("stall", 2'd0, 0, 1, 1'b0, '0, 1'b0);
    // Outline ops (empty without the frame feature).
    wr(1, xy(2, 2));
    do_op("frame3x3", 2'd2, 0, -1, 1'b0, '0, 1'b0);
    wr(0, xy(10, 20)); wr(1, xy(14, 23));
    do_op("frame5x4", 2'd2, 30, -1, 1'b0, '0, 1'b0);
    wr(1, xy(10, 24));
    do_op("frame1w", 2'd2, 0, -1, 1'b0, '0, 1'b0);
    // TL written while busy must be ignored.
    wr(0, xy(1, 1)); wr(1, xy(3, 2));
    do_op("busytl", 2'd0, 0, -1, 1'b0, '0, 1'b1);
    do_op("aftbusy", 2'd0, 0, -1, 1'b0, '0, 1'b0);
    // TL written in the start cycle: op uses old TL, next op the new one.
    do_op("simtl", 2'd0, 0, -1, 1'b1, xy(2, 2), 1'b0);
    do_op("newtl", 2'd0, 0, -1, 1'b0, '0, 1'b0);

    // Clear: check the first pixels, then abort with reset.
    wr(2, 32'h0000_0ABC);
    bus.ctrl_we = 1'b1; bus.ctrl_in = 32'h0000_0003;
    @(posedge clk); #1;
    bus.ctrl_we = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("clear we", {31'd0, bus.vram_we}, 32'd1);
      check("clear addr", 32'(bus.vram_addr), 32'(i));
      check("clear data", 32'(bus.vram_data), 32'h0ABC);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort we", {31'd0, bus.vram_we}, 32'd0);
    check("abort finish", {31'd0, bus.finish}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort quiet", {31'd0, bus.vram_we}, 32'd0);
    end
    m_tl = '0; m_br = '0; m_col = '0;
    do_op("postrst", 2'd0, 0, -1, 1'b0, '0, 1'b0);

    // Randomized rectangles.
    for (int it = 0; it < 30; it++) begin
      int rx0, ry0, rx1, ry1, pct;
      logic [1:0] rop;
      rx0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(310, 330)) : int'($urandom_range(0, 20));
      ry0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(232, 250)) : int'($urandom_range(0, 20));
      rx1 = (rx0 > 0 && $urandom_range(0, 7) == 0) ? rx0 - 1 : rx0 + int'($urandom_range(0, 6));
      ry1 = (ry0 > 0 && $urandom_range(0, 7) == 0) ? ry0 - 1 : ry0 + int'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0, 1:    rop = 2'd0;
        2:       rop = 2'd2;
        default: rop = 2'd3;
      endcase
      pct = ($urandom_range(0, 1) == 0) ? 0 : 30;
      wr(0, xy(rx0, ry0)); wr(1, xy(rx1, ry1)); wr(2, $urandom);
      do_op("rand", rop, pct, -1, 1'b0, '0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gp_rect_engine.md
# gp_rect_engine

Memory-mapped 2-D drawing engine on the CPU I/O bus at 0xC0000000. It latches corner, color and control words written by the CPU through the bus decoder's `gp_*` strobes. It then streams pixel writes into the frame-buffer VRAM and drives `finish`, which the CPU polls at offset 4. It is the responder for the bus decoder's graphic-processor window.

## Interface
Parameters:
- `H_RES`, 320, frame width in pixels
- `V_RES`, 240, frame height in pixels
- `AW`, 17, VRAM address width (word = pixel)
- `CW`, 12, color width (RGB444)

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `ctrl_we` in 1 / `ctrl_in` in 32: control write; [0] start, [2:1] op
- `tl_we` in 1 / `tl_in` in 32: top-left corner; x0=[25:16], y0=[9:0]
- `br_we` in 1 / `br_in` in 32: bottom-right corner, inclusive; x1=[25:16], y1=[9:0]
- `arg_we` in 1 / `arg_in` in 32: color = [CW-1:0]
- `finish` out 1: 1 = idle/done, 0 = operation in progress
- `vram_we` out 1: pixel write valid
- `vram_addr` out AW: pixel address = y*H_RES + x
- `vram_data` out CW: pixel color
- `vram_stall` in 1: VRAM cannot accept the current write

## Operation
- Registers TL, BR, COLOR are loaded on their `_we` only while `finish`=1. Writes while busy are ignored.
- `ctrl_we` with `ctrl_in[0]`=1 while idle starts the op in `ctrl_in[2:1]`. Start while busy is ignored. `ctrl_in[0]`=0 is a no-op.
- Ops:
  - 0 FILL: every pixel in the rectangle TL..BR gets COLOR.
  - 1 CLEAR: whole screen 0..H_RES-1 × 0..V_RES-1 gets COLOR; TL/BR are ignored.
  - 2 FRAME: outline only (see Configuration).
  - 3 reserved: behaves as an empty op.
- States:
  - IDLE: on valid start go to SETUP.
  - SETUP: clip x0,x1 to H_RES-1 and y0,y1 to V_RES-1. Load row base = y0*H_RES. If x0>x1 or y0>y1 (after clip) or op empty, go to DONE. Otherwise go to DRAW.
  - DRAW: raster order, x inner, y outer, one pixel per accepted cycle. At x=x1, set x=x0, y+1, and row base += H_RES. After (x1,y1) is accepted, go to DONE.
  - DONE: for one cycle, then IDLE.
- Row base is computed incrementally; no multiplier in the DRAW path. SETUP y0*H_RES may use shift-add for the default H_RES.
- Outputs reset to: `finish`=1, `vram_we`=0, `vram_addr`=0, `vram_data`=0. TL=BR=COLOR=0, state IDLE.
- `rst` mid-operation aborts immediately. No further `vram_we`, `finish`=1 next cycle.

## Timing
- Start write in cycle N: `finish`=0 from N+1, SETUP in N+1, first `vram_we` in N+2.
- A write is accepted in a cycle where `vram_we`=1 and `vram_stall`=0. While stalled, `vram_we`/`vram_addr`/`vram_data` hold stable.
- Last write accepted in cycle M: `vram_we`=0 in M+1 (DONE), `finish`=1 from M+2. A new start is accepted in cycle M+2.
- Empty op started in N: `finish`=1 again at N+3.
- FILL of W×H pixels with no stall: `finish` returns at N+2+W*H+1.
- Simultaneous `tl_we` and `ctrl_we` in the same idle cycle: the new TL is latched, but the started op uses the old TL.

## Configuration
- `GP_FRAME_EN` defined: op 2 draws only pixels with x∈{x0,x1} or y∈{y0,y1}.
  - Interior rows write x0 then jump straight to x1, taking 2 cycles per row. Top and bottom rows are written fully.
  - Degenerate width (x0=x1) writes each pixel once. No address is written twice.
- `GP_FRAME_EN` undefined: op 2 behaves as reserved/empty. `finish` returns 3 cycles after start with no VRAM writes, and the frame logic is absent.

## Test plan
- Reset, then idle: `finish`=1 and `vram_we`=0. Then TL=(2,1), BR=(4,2), color 0xF00, FILL start -> 6 writes at addrs 322,323,324,642,643,644, all data 0xF00. `finish`=1 nine cycles after the start write.
- FILL with BR=(500,300), TL=(318,238) -> clipped to x 318..319, y 238..239. Writes are 76478,76479,76798,76799.
- Inverted rectangle TL=(5,5), BR=(3,5) -> no writes, `finish` back at N+3. Op 3 gives the same result.
- FILL 3×1 with `vram_stall` high for 2 cycles on the second pixel -> addr/data held for those cycles, exactly 3 accepted writes, `finish` delayed by 2 cycles.
- Write TL while busy, then `rst` mid-FILL -> TL unchanged during the op. After reset, `vram_we`=0 and `finish`=1 the next cycle, and all registers read back as 0 on the next FILL.
- `GP_FRAME_EN` set, FRAME TL=(0,0), BR=(2,2) -> 8 writes, addr 321 never written. With the macro unset -> 0 writes.
